// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, flag layout,
// error byte and controller state encoding.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_SRA = 6'h03;

    localparam int FLG_Z = 0;
    localparam int FLG_V = 1;
    localparam int FLG_C = 2;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND_RES,
        ST_WAIT_RES,
        ST_SEND_FLG,
        ST_WAIT_FLG,
        ST_SEND_ERR,
        ST_WAIT_ERR
    } ctrl_state_t;

    // Builds the flags byte returned after the result: {5'b0, carry, overflow, zero}.
    function automatic logic [7:0] pack_flags(input logic zero,
                                              input logic overflow,
                                              input logic carry);
        logic [7:0] f;
        f        = '0;
        f[FLG_Z] = zero;
        f[FLG_V] = overflow;
        f[FLG_C] = carry;
        return f;
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// expire on the cycle the count would reach TIMEOUT. TIMEOUT=0 never expires.
module byte_timeout #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    assign expire = (TIMEOUT != 0) && enable && (count == LAST);

    // Count waiting cycles; a new byte or an expiry restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Command sequencer between a UART byte interface and an ALU. Gathers A, B
// and opcode bytes, lets the ALU settle for one cycle, then returns the
// result byte followed by a flags byte. Bad opcodes answer with ERR_BYTE.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_done,
    input  logic             i_tx_done,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    output logic [N-1:0]     o_alu_a,
    output logic [N-1:0]     o_alu_b,
    output logic [NB_OP-1:0] o_alu_op,
    input  logic [N-1:0]     i_alu_result,
    input  logic             i_alu_zero,
    input  logic             i_alu_overflow,
    input  logic             i_alu_carry,
    output logic             o_busy
);

    // Operands travel one per byte, so only an 8-bit ALU is supported.
    if (N != 8) begin : g_bad_width
        $error("alu_uart_ctrl: N must be 8");
    end

    ctrl_state_t state, state_next;

    logic [7:0] flags;
    logic       load_a, load_b, load_op, load_err, load_res, load_flg;
    logic       tmo_enable, tmo_expire;

    byte_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (i_rx_done),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus register load strobes and status outputs.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        load_err   = 1'b0;
        load_res   = 1'b0;
        load_flg   = 1'b0;
        o_tx_start = 1'b0;
        tmo_enable = 1'b0;
        o_busy     = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    load_a     = 1'b1;
                    state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                tmo_enable = 1'b1;
                // A byte arriving on the expiry cycle still counts.
                if (i_rx_done) begin
                    load_b     = 1'b1;
                    state_next = ST_WAIT_OP;
                end else if (tmo_expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_OP: begin
                tmo_enable = 1'b1;
                if (i_rx_done) begin
                    if (i_rx_data[7:6] == 2'b00) begin
                        load_op    = 1'b1;
                        state_next = ST_EXEC;
                    end else begin
                        load_err   = 1'b1;
                        state_next = ST_SEND_ERR;
                    end
                end else if (tmo_expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                load_res   = 1'b1;
                state_next = ST_SEND_RES;
            end
            ST_SEND_RES: begin
                o_tx_start = 1'b1;
                state_next = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (i_tx_done) begin
                    load_flg   = 1'b1;
                    state_next = ST_SEND_FLG;
                end
            end
            ST_SEND_FLG: begin
                o_tx_start = 1'b1;
                state_next = ST_WAIT_FLG;
            end
            ST_WAIT_FLG: begin
                if (i_tx_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SEND_ERR: begin
                o_tx_start = 1'b1;
                state_next = ST_WAIT_ERR;
            end
            ST_WAIT_ERR: begin
                if (i_tx_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand, opcode, transmit byte and flag registers; all hold between commands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
            flags     <= '0;
        end else begin
            if (load_a) begin
                o_alu_a <= i_rx_data;
            end
            if (load_b) begin
                o_alu_b <= i_rx_data;
            end
            if (load_op) begin
                o_alu_op <= NB_OP'(i_rx_data[5:0]);
            end
            if (load_err) begin
                o_tx_data <= ERR_BYTE;
            end
            if (load_res) begin
                o_tx_data <= i_alu_result;
                flags     <= pack_flags(i_alu_zero, i_alu_overflow, i_alu_carry);
            end
            if (load_flg) begin
                o_tx_data <= flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Testbench for alu_uart_ctrl: UART rx/tx models, a behavioural 8-bit ALU,
// a queue-based scoreboard and a reference model of each command's reply.
module tb_alu_uart_ctrl;
    import alu_pkg::*;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_res;
    logic       alu_z, alu_v, alu_c;
    logic       busy;

    int total  = 0;
    int bad    = 0;
    int starts = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_a  = 8'h00;
    logic [7:0] exp_b  = 8'h00;
    logic [5:0] exp_op = 6'h00;

    alu_uart_ctrl #(
        .N       (8),
        .NB_OP   (6),
        .TIMEOUT (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_done      (rx_done),
        .i_tx_done      (tx_done),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .i_alu_result   (alu_res),
        .i_alu_zero     (alu_z),
        .i_alu_overflow (alu_v),
        .i_alu_carry    (alu_c),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Combinational ALU attached to the controller's operand registers.
    always_comb begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_v = (alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]);
            end
            OP_SUB: begin
                {alu_c, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
                alu_v = (alu_a[7] != alu_b[7]) && (alu_res[7] != alu_a[7]);
            end
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_XOR:  alu_res = alu_a ^ alu_b;
            OP_NOR:  alu_res = ~(alu_a | alu_b);
            OP_SRL:  alu_res = alu_a >> alu_b;
            OP_SRA:  alu_res = 8'($signed(alu_a) >>> alu_b);
            default: alu_res = 8'h00;
        endcase
        alu_z = (alu_res == 8'h00);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: expected reply bytes for one command, from plain integer arithmetic.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        int ua, ub, sa, sb, r, s;
        bit c, v;
        exp_a = a;
        exp_b = b;
        if (op[7:6] != 2'b00) begin
            exp_q.push_back(ERR_BYTE);
            return;
        end
        exp_op = op[5:0];
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 1'b0;
        v = 1'b0;
        case (op[5:0])
            OP_ADD: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            OP_SUB: begin r = ua - ub; c = (r < 0);   s = sa - sb; v = (s > 127) || (s < -128); end
            OP_AND:  r = ua & ub;
            OP_OR:   r = ua | ub;
            OP_XOR:  r = ua ^ ub;
            OP_NOR:  r = ~(ua | ub);
            OP_SRL:  r = (ub > 7) ? 0 : (ua >> ub);
            OP_SRA:  r = (ub > 7) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
            default: r = 0;
        endcase
        r = r & 255;
        exp_q.push_back(8'(r));
        exp_q.push_back({5'b0, c, v, (r == 0)});
    endtask

    // Called 1ns after a rising edge; the byte is sampled on the next edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_idle"}, int'(busy), 0);
        check({name, "_resp_left"}, exp_q.size(), 0);
    endtask

    task automatic check_regs(input string name);
        check({name, "_a"},  int'(alu_a),  int'(exp_a));
        check({name, "_b"},  int'(alu_b),  int'(exp_b));
        check({name, "_op"}, int'(alu_op), int'(exp_op));
    endtask

    task automatic run_cmd(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input int gap);
        model(a, b, op);
        send_byte(a);
        idle(gap);
        send_byte(b);
        idle(gap);
        send_byte(op);
        if (op[7:6] == 2'b00) begin
            check({name, "_exec_nostart"}, int'(tx_start), 0);
            idle(1);
            check({name, "_res_start"}, int'(tx_start), 1);
        end else begin
            check({name, "_err_start"}, int'(tx_start), 1);
        end
        wait_idle(name);
        check_regs(name);
    endtask

    // Scoreboard monitor: every tx_start must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            starts++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx: got start with byte %02h, required no start", tx_data);
            end else begin
                check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
            end
        end
    end

    // UART transmitter model: tx_done pulse about 10 cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                repeat (10) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops [8];
        logic [7:0] a, b, op;
        int st0, idx;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA};

        #12;
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data",  int'(tx_data),  0);
        check("rst_busy",     int'(busy),     0);
        check("rst_alu_a",    int'(alu_a),    0);
        check("rst_alu_op",   int'(alu_op),   0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        run_cmd("add_basic", 8'h05, 8'h03, 8'h20, 0);
        run_cmd("add_ovf",   8'h7F, 8'h01, 8'h20, 2);
        run_cmd("add_carry", 8'hFF, 8'h01, 8'h20, 1);
        run_cmd("sub_zero",  8'h0A, 8'h0A, 8'h22, 0);
        run_cmd("bad_op",    8'h11, 8'h22, 8'hE0, 0);

        // Timeout abandons a partial command without transmitting.
        st0 = starts;
        send_byte(8'h33);
        exp_a = 8'h33;
        idle(15);
        check("tmo_before", int'(busy), 1);
        idle(1);
        check("tmo_expired", int'(busy), 0);
        check("tmo_keep_a", int'(alu_a), 8'h33);
        check("tmo_no_tx", starts, st0);
        run_cmd("after_tmo", 8'h01, 8'h02, 8'h20, 0);
        run_cmd("rx_on_expiry", 8'h5A, 8'h21, {2'b00, OP_XOR}, 15);

        // Bytes arriving while a reply is in flight are dropped.
        st0 = starts;
        model(8'h05, 8'h03, 8'h20);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        idle(3);
        send_byte(8'h99);
        send_byte(8'h98);
        wait_idle("drop");
        check_regs("drop");
        idle(20);
        check("drop_two_tx", starts, st0 + 2);

        // Reset during WAIT_RES clears outputs and cancels the flags byte.
        model(8'h12, 8'h34, {2'b00, OP_AND});
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte({2'b00, OP_AND});
        idle(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  int'(busy),     0);
        check("mid_rst_start", int'(tx_start), 0);
        check("mid_rst_data",  int'(tx_data),  0);
        check("mid_rst_a",     int'(alu_a),    0);
        check("mid_rst_b",     int'(alu_b),    0);
        check("mid_rst_op",    int'(alu_op),   0);
        check("mid_rst_res_sent", exp_q.size(), 1);
        exp_q.delete();
        exp_a = 8'h00;
        exp_b = 8'h00;
        exp_op = 6'h00;
        st0 = starts;
        idle(3);
        rst_n = 1'b1;
        idle(30);
        check("post_rst_no_tx", starts, st0);
        check("post_rst_busy", int'(busy), 0);

        // Randomized commands with random inter-byte gaps.
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            idx = int'($urandom_range(0, 9));
            if (idx < 8) begin
                op = {2'b00, ops[idx]};
            end else if (idx == 8) begin
                op = {2'($urandom_range(1, 3)), 6'($urandom)};
            end else begin
                op = {2'b00, 6'($urandom)};
            end
            run_cmd("rand", a, b, op, int'($urandom_range(0, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
